multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath: sequences fetch,
// decode, memory, execute and write-back steps and decodes datapath strobes.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_IDLE     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  state_t state, next_state;

  // Reset lands in IDLE from any state, including a stalled memory access.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  assign State = state;

  always_comb begin
    next_state  = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    IllegalOp   = 1'b0;

    unique case (state)
      S_IDLE: next_state = S_FETCH;

      // Instruction fetch; the IR and PC update only once memory answers.
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = MemReady;
        PCWrite    = MemReady;
        next_state = MemReady ? S_DECODE : S_FETCH;
      end

      // Branch target computed speculatively while the opcode is decoded.
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:      next_state = S_EXECUTE;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_ADDIEX;
          default: begin
            IllegalOp  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MemReady ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        next_state = MemReady ? S_FETCH : S_MEMWRITE;
      end

      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_RTYPE;
        next_state = S_RWB;
      end

      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      // PC is written only if the ALU subtract reports equality.
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        next_state  = S_FETCH;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        next_state = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end

      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle scoreboard bench for multicycle_control: expected state and
// control word are queued as each cycle's stimulus is applied, then compared.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
  } exp_t;

  exp_t sb_q[$];

  multicycle_control dut (
    .clock(clock), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg
  // ALUSrcA RegWrite RegDst PCSource[1:0] ALUSrcB[1:0] ALUOp[1:0] IllegalOp
  function automatic logic [16:0] pack(input logic pcw, pcwc, iord, mrd, mwr,
                                       irw, m2r, asa, rw, rd,
                                       input logic [1:0] pcs, asb, aop,
                                       input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, asb, aop, ill};
  endfunction

  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic [5:0] op);
    logic ill;
    ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
    case (st)
      4'd0:  return pack(mr,0,0,1,0,mr,0,0,0,0, 2'b00,2'b01,2'b00, 0);
      4'd1:  return pack(0,0,0,0,0,0,0,0,0,0,   2'b00,2'b11,2'b00, ill);
      4'd2:  return pack(0,0,0,0,0,0,0,1,0,0,   2'b00,2'b10,2'b00, 0);
      4'd3:  return pack(0,0,1,1,0,0,0,0,0,0,   2'b00,2'b00,2'b00, 0);
      4'd4:  return pack(0,0,0,0,0,0,1,0,1,0,   2'b00,2'b00,2'b00, 0);
      4'd5:  return pack(0,0,1,0,1,0,0,0,0,0,   2'b00,2'b00,2'b00, 0);
      4'd6:  return pack(0,0,0,0,0,0,0,1,0,0,   2'b00,2'b00,2'b10, 0);
      4'd7:  return pack(0,0,0,0,0,0,0,0,1,1,   2'b00,2'b00,2'b00, 0);
      4'd8:  return pack(0,1,0,0,0,0,0,1,0,0,   2'b01,2'b00,2'b01, 0);
      4'd9:  return pack(1,0,0,0,0,0,0,0,0,0,   2'b10,2'b00,2'b00, 0);
      4'd10: return pack(0,0,0,0,0,0,0,1,0,0,   2'b00,2'b10,2'b00, 0);
      4'd11: return pack(0,0,0,0,0,0,0,0,1,0,   2'b00,2'b00,2'b00, 0);
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [16:0] dut_ctrl();
    return pack(PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, IllegalOp);
  endfunction

  // Apply one cycle of stimulus, queue the expectation, compare, then clock.
  task automatic cyc(input string tag, input logic [5:0] op, input logic mr,
                     input logic [3:0] st);
    exp_t e;
    Op       = op;
    MemReady = mr;
    sb_q.push_back('{st: st, ctrl: exp_ctrl(st, mr, op)});
    #2;
    if (sb_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_state"}, {28'd0, State}, {28'd0, e.st});
      chk({tag, "_ctrl"}, {15'd0, dut_ctrl()}, {15'd0, e.ctrl});
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    Op = 6'h00;
    MemReady = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("reset_state", {28'd0, State}, 32'd15);
    chk("reset_ctrl", {15'd0, dut_ctrl()}, 32'd0);
    reset = 1'b0;

    // lw: 15,0,1,2,3,4,0 ; Op changes in MEMREAD/MEMWB are ignored
    cyc("lw", 6'h23, 1, 15);
    cyc("lw", 6'h23, 1, 0);
    cyc("lw", 6'h23, 1, 1);
    cyc("lw", 6'h23, 1, 2);
    cyc("lw", 6'h04, 1, 3);
    cyc("lw", 6'h3F, 1, 4);

    // R-type: FETCH, DECODE, EXECUTE, RWB, back to FETCH
    cyc("rtype", 6'h00, 1, 0);
    cyc("rtype", 6'h00, 1, 1);
    cyc("rtype", 6'h02, 1, 6);
    cyc("rtype", 6'h23, 1, 7);

    // FETCH stall three cycles, then beq
    cyc("fstall", 6'h04, 0, 0);
    cyc("fstall", 6'h04, 0, 0);
    cyc("fstall", 6'h04, 0, 0);
    cyc("fstall", 6'h04, 1, 0);
    cyc("beq", 6'h04, 1, 1);
    cyc("beq", 6'h00, 1, 8);

    // sw with two stalled MEMWRITE cycles
    cyc("sw", 6'h2B, 1, 0);
    cyc("sw", 6'h2B, 1, 1);
    cyc("sw", 6'h2B, 1, 2);
    cyc("sw", 6'h23, 0, 5);
    cyc("sw", 6'h23, 0, 5);
    cyc("sw", 6'h23, 1, 5);

    // j
    cyc("j", 6'h02, 1, 0);
    cyc("j", 6'h02, 1, 1);
    cyc("j", 6'h08, 1, 9);

    // addi
    cyc("addi", 6'h08, 1, 0);
    cyc("addi", 6'h08, 1, 1);
    cyc("addi", 6'h00, 1, 10);
    cyc("addi", 6'h00, 1, 11);

    // illegal opcodes
    cyc("ill3f", 6'h3F, 1, 0);
    cyc("ill3f", 6'h3F, 1, 1);
    cyc("ill01", 6'h01, 1, 0);
    cyc("ill01", 6'h01, 1, 1);

    // reset in the middle of a stalled load
    cyc("rstmid", 6'h23, 1, 0);
    cyc("rstmid", 6'h23, 1, 1);
    cyc("rstmid", 6'h23, 1, 2);
    cyc("rstmid", 6'h23, 0, 3);
    Op = 6'h23;
    MemReady = 1'b0;
    reset = 1'b1;
    #2;
    chk("rstmid_pre", {28'd0, State}, 32'd3);
    @(posedge clock); #1;
    chk("rstmid_state", {28'd0, State}, 32'd15);
    chk("rstmid_ctrl", {15'd0, dut_ctrl()}, 32'd0);
    reset = 1'b0;
    cyc("post_rst", 6'h23, 0, 15);
    cyc("post_rst", 6'h23, 0, 0);
    cyc("final", 6'h00, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
